serial_adder: RTL and testbench

Bit-serial, LSB-first multi-bit adder built around the team's single-bit `fa_module` full-adder cell. It is the stage directly upstream of and wrapping that cell: it feeds `A`, `B`, `Cin` one bit per clock and consumes `S` and `Cout`. `Cout` is registered and fed back as the next bit's `Cin`. The block trades latency for area, so a WIDTH-bit add costs one full-adder cell plus shift registers. It is intended for the tile's arithmetic datapath.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/fa_module.sv | 16 +
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   sa_state_e   : controller state encoding (IDLE, RUN, DONE)
//   SA_MAX_WIDTH : widest operand the adder accepts
package serial_adder_pkg;

    localparam int SA_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/fa_module.sv
// fa_module
//   Single-bit full-adder cell.
//   A, B, Cin : addend bits and carry-in
//   S, Cout   : sum bit and carry-out
module fa_module (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial, LSB-first adder: one full-adder cell, operand/sum shift
//   registers and a registered carry. {cout,sum} = a + b + cin after WIDTH
//   RUN cycles; done pulses for one cycle when the result is valid.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : request an add (accepted only in IDLE)
//   a, b, cin   : operands, captured on the accepted start edge
//   busy        : high whenever the controller is not IDLE
//   done        : one-cycle result-valid pulse
//   sum, cout   : result, held until the next accepted start
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last result
// RUN   | one bit per cycle through the full adder, LSB first
// DONE  | result valid, done pulse; returns to IDLE unconditionally
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SA_MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH must lie in 2..%0d", SA_MAX_WIDTH);
    end

    sa_state_e        state;
    sa_state_e        state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;

    fa_module u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // after WIDTH shifts the first (LSB) sum bit lands in bit 0
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_sh;
    assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_assert = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one add in the current cycle (index 0) and observe 14 cycles.
    // If repulse_at > 0, start is re-asserted with 0x01+0x01 in that cycle.
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input int repulse_at,
                           output int first_done, output int n_done,
                           output int n_busy);
        first_done = -1;
        n_done     = 0;
        n_busy     = 0;
        a = av; b = bv; cin = cv; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            if (i == repulse_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    int fd, nd, nb;
    int done_idx[$];

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        // basic add
        run_add(8'h3C, 8'h5A, 1'b0, 0, fd, nd, nb);
        chk("basic_done_cycle", 32'(fd), 32'd9);
        chk("basic_done_count", 32'(nd), 32'd1);
        chk("basic_busy_cycles", 32'(nb), 32'd9);
        chk("basic_sum",  32'(sum),  32'h96);
        chk("basic_cout", 32'(cout), 32'd0);

        // full carry ripple
        run_add(8'hFF, 8'h01, 1'b0, 0, fd, nd, nb);
        chk("ripple_done_cycle", 32'(fd), 32'd9);
        chk("ripple_sum",  32'(sum),  32'h00);
        chk("ripple_cout", 32'(cout), 32'd1);

        // all ones with carry-in
        run_add(8'hFF, 8'hFF, 1'b1, 0, fd, nd, nb);
        chk("ones_sum",  32'(sum),  32'hFF);
        chk("ones_cout", 32'(cout), 32'd1);

        // start while busy is ignored
        run_add(8'h10, 8'h20, 1'b0, 3, fd, nd, nb);
        chk("busy_start_done_count", 32'(nd), 32'd1);
        chk("busy_start_done_cycle", 32'(fd), 32'd9);
        chk("busy_start_sum",  32'(sum),  32'h30);
        chk("busy_start_cout", 32'(cout), 32'd0);

        // reset mid-operation
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        // start together with reset: reset wins
        start = 1'b1;
        tick();
        chk("rst_start_busy", 32'(busy), 32'd0);
        start = 1'b0; rst = 1'b0;
        tick();
        run_add(8'h07, 8'h09, 1'b0, 0, fd, nd, nb);
        chk("post_rst_done_cycle", 32'(fd), 32'd9);
        chk("post_rst_sum",  32'(sum),  32'h10);
        chk("post_rst_cout", 32'(cout), 32'd0);

        // back-to-back with start held high
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin
                done_idx.push_back(i);
                chk("b2b_sum",  32'(sum),  32'h00);
                chk("b2b_cout", 32'(cout), 32'd1);
            end
            if (i == 10 || i == 20) begin
                chk("b2b_hold_sum",  32'(sum),  32'h00);
                chk("b2b_hold_cout", 32'(cout), 32'd1);
                chk("b2b_idle_busy", 32'(busy), 32'd0);
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(done_idx.size()), 32'd3);
        if (done_idx.size() == 3) begin
            chk("b2b_done0", 32'(done_idx[0]), 32'd9);
            chk("b2b_done1", 32'(done_idx[1]), 32'd19);
            chk("b2b_done2", 32'(done_idx[2]), 32'd29);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
